image_read_stream: RTL
======================

Name: image_read_stream

Overview:
- Frame-readout engine: the transmit-side counterpart of the frame writer.
- Fetches a stored 24-bit BMP-ordered image from a synchronous frame memory, two pixels per word, and emits it as a raster pixel stream.
- Stream is top row first, even/odd pixel pairs, one pair per active cycle, with a vertical start-up gap and horizontal blanking gaps.
- Output ports connect directly to the frame writer's data_write / DATA_WRITE_* inputs, so a read-process-write loop needs no glue.

Parameters:
- WIDTH, 768, image width in pixels; must be even.
- HEIGHT, 512, image height in rows.
- START_UP_DELAY, 100, cycles VSYNC is held high after start, before the first row.
- HSYNC_DELAY, 160, blanking cycles before every row, including the first.
- ADDR_W, 18, memory word-address width; requires 2^ADDR_W >= WIDTH*HEIGHT/2.

Ports:
- HCLK  in  1  clock, rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle frame request; ignored unless idle.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_W  word address, valid when mem_rd=1.
- mem_rdata  in  48  read word, valid the cycle after mem_rd. Layout: [23:16]=R0, [15:8]=G0, [7:0]=B0, [47:40]=R1, [39:32]=G1, [31:24]=B1.
- VSYNC  out  1  high throughout the start-up gap.
- data_write  out  1  pixel-pair valid strobe.
- DATA_R0, DATA_G0, DATA_B0  out  8 each  even pixel.
- DATA_R1, DATA_G1, DATA_B1  out  8 each  odd pixel.
- busy  out  1  high from the cycle after an accepted start until ctrl_done.
- ctrl_done  out  1  one-cycle frame-complete pulse.

Behaviour:
- Reset (asynchronous, any time, including mid-frame): state IDLE; all outputs 0; row and column counters 0; the in-flight read is discarded. No partial completion pulse.
- FSM states: IDLE, VSYNC, HSYNC, DATA, FLUSH, DONE.
- IDLE: on start=1 go to VSYNC with delay counter = 0.
- VSYNC: VSYNC=1 for exactly START_UP_DELAY cycles, then go to HSYNC.
- HSYNC: exactly HSYNC_DELAY cycles with no reads, then go to DATA with column = 0.
- DATA: exactly WIDTH/2 cycles with mem_rd=1.
  - mem_addr = (HEIGHT-1-row)*(WIDTH/2) + col. Storage is bottom-up, matching the writer's layout.
  - After the last column: if row < HEIGHT-1, increment row and go to HSYNC; otherwise go to FLUSH.
- FLUSH: 2 cycles so the final beat reaches the outputs, then go to DONE.
- DONE: ctrl_done=1 for one cycle, busy falls in the same cycle, then go to IDLE.
- Data path latency:
  - mem_rd in cycle t gives mem_rdata in t+1.
  - Pixel registers capture mem_rdata at the end of t+1.
  - data_write and DATA_* are valid in cycle t+2.
- data_write is a two-stage delayed copy of mem_rd. DATA_* hold their last value when data_write=0.
- Exactly WIDTH*HEIGHT/2 data_write beats per frame, with no gaps inside a row.
- The last beat occurs 1 cycle before ctrl_done.
- start while busy or in DONE is ignored, with no restart. A start in the cycle DONE returns to IDLE is accepted on the next cycle only.
- Counter widths:
  - row: ceil(log2(HEIGHT)).
  - col: ceil(log2(WIDTH/2)).
  - delay counter: wide enough for max(START_UP_DELAY, HSYNC_DELAY).
  - Address arithmetic is unsigned at ADDR_W bits, with no wrap for legal parameters.
- Frame cycle count from start to ctrl_done = 1 + START_UP_DELAY + HEIGHT*(HSYNC_DELAY + WIDTH/2) + 2 + 1.

Decomposition:
- Shared image package holds:
  - the state enumeration;
  - BMP_HEADER_NUM = 54;
  - the pixel-pair word layout constants (bit offsets of R0..B1);
  - helper function pair_addr(row, col, WIDTH, HEIGHT).
- The writer and the future processing blocks reuse the same package.
- One natural sub-module, image_read_addr_gen: owns the row/column counters and the address computation. The top level keeps the FSM, delay counter and output pipeline.

Test Plan (bench params WIDTH=8, HEIGHT=4, START_UP_DELAY=3, HSYNC_DELAY=2, memory model word k = {k+100, k+50, k, k+3, k+2, k+1} in 8-bit fields):
- Reset then start pulse -> VSYNC high for exactly 3 cycles; first mem_rd 5 cycles after start acceptance, mem_addr=12 (row 0 reads bottom stored row); first data_write 2 cycles later with B0=13, G0=14, R0=15.
- Full frame -> exactly 16 data_write beats in 4 bursts of 4; address sequence 12..15, 8..11, 4..7, 0..3; 2-cycle gaps between bursts; ctrl_done exactly 1 cycle after beat 16; total 1+3+4*(2+4)+2+1 = 31 cycles.
- start re-asserted in VSYNC, DATA and DONE -> no restart; beat count stays 16; exactly one ctrl_done pulse.
- HRESETn asserted mid-row 2 -> all outputs 0 immediately; no ctrl_done. A fresh start then produces a full 16-beat frame beginning at address 12.
- Loopback with frame writer (WIDTH=8, HEIGHT=4) -> the writer's stored memory equals the source memory byte-for-byte.
- Back-to-back frames with start on the cycle after ctrl_done -> second frame identical in timing and data to the first.

Source files
------------

// File: rtl/image_pkg.sv
// Shared image definitions: readout FSM states, BMP pixel-pair word layout
// and the bottom-up frame-memory addressing used by the reader and writer.
package image_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_HSYNC,
    ST_DATA,
    ST_FLUSH,
    ST_DONE
  } state_t;

  localparam int unsigned BMP_HEADER_NUM = 54;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned WORD_W = 48;

  // Bit offsets of each colour byte inside one 48-bit pixel-pair word
  localparam int unsigned B0_LSB = 0;
  localparam int unsigned G0_LSB = 8;
  localparam int unsigned R0_LSB = 16;
  localparam int unsigned B1_LSB = 24;
  localparam int unsigned G1_LSB = 32;
  localparam int unsigned R1_LSB = 40;

  // Rows are stored bottom-up, so raster row 0 lives in the last stored row
  function automatic int unsigned pair_addr(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned width,
                                            input int unsigned height);
    return (height - 1 - row) * (width / 2) + col;
  endfunction

endpackage

// File: rtl/image_read_addr_gen.sv
// Row/column counters for frame readout; each issue registers the word address
// for the current pair and advances to the next one in raster order.
module image_read_addr_gen
  import image_pkg::*;
#(
  parameter int unsigned WIDTH  = 768,
  parameter int unsigned HEIGHT = 512,
  parameter int unsigned ADDR_W = 18
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_issue,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last_col,
  output logic              o_last_row
);

  localparam int unsigned HALF_W = WIDTH / 2;
  localparam int unsigned ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned COL_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [ADDR_W-1:0] r_addr;
  logic              r_last_col;
  logic              r_last_row;
  logic              w_col_end;
  logic              w_row_end;

  assign w_col_end = (r_col == COL_W'(HALF_W - 1));
  assign w_row_end = (r_row == ROW_W'(HEIGHT - 1));

  // Flags travel with the address so the FSM knows which beat is on the bus
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row      <= '0;
      r_col      <= '0;
      r_addr     <= '0;
      r_last_col <= 1'b0;
      r_last_row <= 1'b0;
    end else if (i_clr) begin
      r_row      <= '0;
      r_col      <= '0;
    end else if (i_issue) begin
      r_addr     <= ADDR_W'(pair_addr(32'(r_row), 32'(r_col), WIDTH, HEIGHT));
      r_last_col <= w_col_end;
      r_last_row <= w_row_end;
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign o_addr     = r_addr;
  assign o_last_col = r_last_col;
  assign o_last_row = r_last_row;

endmodule

// File: rtl/image_read_stream.sv
// Frame-readout engine: fetches a bottom-up stored BMP image two pixels per
// word and streams it top row first with vertical and horizontal blanking.
module image_read_stream
  import image_pkg::*;
#(
  parameter int unsigned WIDTH          = 768,
  parameter int unsigned HEIGHT         = 512,
  parameter int unsigned START_UP_DELAY = 100,
  parameter int unsigned HSYNC_DELAY    = 160,
  parameter int unsigned ADDR_W         = 18
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [47:0]       mem_rdata,
  output logic              VSYNC,
  output logic              data_write,
  output logic [7:0]        DATA_R0,
  output logic [7:0]        DATA_G0,
  output logic [7:0]        DATA_B0,
  output logic [7:0]        DATA_R1,
  output logic [7:0]        DATA_G1,
  output logic [7:0]        DATA_B1,
  output logic              busy,
  output logic              ctrl_done
);

  localparam int unsigned DLY_MAX0 = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
  localparam int unsigned DLY_MAX  = (DLY_MAX0 > 2) ? DLY_MAX0 : 2;
  localparam int unsigned DLY_W    = $clog2(DLY_MAX + 1);

  state_t             r_state;
  logic [DLY_W-1:0]   r_dly;
  logic               r_mem_rd;
  logic               r_vsync;
  logic               r_busy;
  logic               r_done;
  logic               r_rd_d1;
  logic               r_data_write;
  logic [PIX_W-1:0]   r_r0, r_g0, r_b0, r_r1, r_g1, r_b1;

  logic               w_clr;
  logic               w_issue;
  logic               w_hsync_end;
  logic               w_last_col;
  logic               w_last_row;

  assign w_clr       = (r_state == ST_IDLE) && start;
  assign w_hsync_end = (r_dly == DLY_W'(HSYNC_DELAY - 1));
  assign w_issue     = ((r_state == ST_HSYNC) && w_hsync_end) ||
                       ((r_state == ST_DATA) && !w_last_col);

  image_read_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_clk      (HCLK),
    .i_rst_n    (HRESETn),
    .i_clr      (w_clr),
    .i_issue    (w_issue),
    .o_addr     (mem_addr),
    .o_last_col (w_last_col),
    .o_last_row (w_last_row)
  );

  // Frame sequencing; outputs change on the same edge as the state they belong to
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= ST_IDLE;
      r_dly    <= '0;
      r_mem_rd <= 1'b0;
      r_vsync  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_VSYNC;
            r_dly   <= '0;
            r_vsync <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_VSYNC: begin
          if (r_dly == DLY_W'(START_UP_DELAY - 1)) begin
            r_state <= ST_HSYNC;
            r_dly   <= '0;
            r_vsync <= 1'b0;
          end else begin
            r_dly <= r_dly + DLY_W'(1);
          end
        end
        ST_HSYNC: begin
          if (w_hsync_end) begin
            r_state  <= ST_DATA;
            r_dly    <= '0;
            r_mem_rd <= 1'b1;
          end else begin
            r_dly <= r_dly + DLY_W'(1);
          end
        end
        ST_DATA: begin
          if (w_last_col) begin
            r_mem_rd <= 1'b0;
            r_state  <= w_last_row ? ST_FLUSH : ST_HSYNC;
          end
        end
        ST_FLUSH: begin
          if (r_dly == DLY_W'(1)) begin
            r_state <= ST_DONE;
            r_dly   <= '0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_dly <= r_dly + DLY_W'(1);
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Two-stage read pipeline: memory latency, then pixel capture
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rd_d1      <= 1'b0;
      r_data_write <= 1'b0;
      r_r0 <= '0; r_g0 <= '0; r_b0 <= '0;
      r_r1 <= '0; r_g1 <= '0; r_b1 <= '0;
    end else begin
      r_rd_d1      <= r_mem_rd;
      r_data_write <= r_rd_d1;
      if (r_rd_d1) begin
        r_r0 <= mem_rdata[R0_LSB +: PIX_W];
        r_g0 <= mem_rdata[G0_LSB +: PIX_W];
        r_b0 <= mem_rdata[B0_LSB +: PIX_W];
        r_r1 <= mem_rdata[R1_LSB +: PIX_W];
        r_g1 <= mem_rdata[G1_LSB +: PIX_W];
        r_b1 <= mem_rdata[B1_LSB +: PIX_W];
      end
    end
  end

  assign mem_rd     = r_mem_rd;
  assign VSYNC      = r_vsync;
  assign busy       = r_busy;
  assign ctrl_done  = r_done;
  assign data_write = r_data_write;
  assign DATA_R0    = r_r0;
  assign DATA_G0    = r_g0;
  assign DATA_B0    = r_b0;
  assign DATA_R1    = r_r1;
  assign DATA_G1    = r_g1;
  assign DATA_B1    = r_b1;

endmodule
